// File: rtl/font_pkg.sv
// -----------------------------------------------------------------------------
// font_pkg
// Shared constants for the font ROM and its users.
//   FONT_ADDR_W / FONT_DATA_W : font ROM address and data widths
//   FONT_BYTES_PER_CHAR       : bytes (scanline rows) per glyph
//   FONT_DEPTH                : populated bytes (128 glyphs x 12 rows)
//   font_addr(ch, row)        : byte address of a glyph row, ch*12 + row
// -----------------------------------------------------------------------------
package font_pkg;

  localparam int FONT_ADDR_W         = 11;
  localparam int FONT_DATA_W         = 8;
  localparam int FONT_BYTES_PER_CHAR = 12;
  localparam int FONT_DEPTH          = 1536;

  function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [6:0] ch,
                                                        input logic [3:0] row);
    return FONT_ADDR_W'(ch) * FONT_ADDR_W'(FONT_BYTES_PER_CHAR) + FONT_ADDR_W'(row);
  endfunction

endpackage

// File: rtl/font_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter_if
// Bundle between the requesters/font ROM and the arbiter.
//   req      : per-requester request, held until granted
//   req_addr : requester i address in bits [i*ADDR_W +: ADDR_W]
//   gnt      : one-hot combinational grant for the current cycle
//   rom_addr : address to the font ROM
//   rom_dout : font ROM data, valid the cycle after its address
//   rdata    : returned byte
//   rvalid   : one-hot owner of rdata this cycle
//   busy_cnt : saturating count of cycles with two or more requests
// Handshake: a requester raises req with a stable address and keeps both
// until it sees its gnt bit high in a cycle; the byte comes back exactly one
// cycle later qualified by its rvalid bit. There is no back-pressure on the
// return path.
// Modports: master = requesters + ROM side, slave = arbiter.
// -----------------------------------------------------------------------------
interface font_rom_arbiter_if
  import font_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = FONT_ADDR_W,
  parameter int DATA_W = FONT_DATA_W
);

  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_dout;
  logic [DATA_W-1:0]      rdata;
  logic [NREQ-1:0]        rvalid;
  logic [15:0]            busy_cnt;

  modport master (
    output req, req_addr, rom_dout,
    input  gnt, rom_addr, rdata, rvalid, busy_cnt
  );

  modport slave (
    input  req, req_addr, rom_dout,
    output gnt, rom_addr, rdata, rvalid, busy_cnt
  );

endinterface

// File: rtl/font_rom_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder: scans req starting at ptr, upward,
// wrapping modulo NREQ; the first set bit wins.
//   req    : request vector
//   ptr    : scan start index
//   gnt    : one-hot winner
//   winner : winner index
//   any    : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ      = 4,
  parameter int NREQ_BITS = 2
) (
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ_BITS-1:0] ptr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ_BITS-1:0] winner,
  output logic                 any
);

  // Walk offsets from farthest to nearest so the nearest requester from ptr
  // is the last assignment and therefore wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        winner   = NREQ_BITS'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
// Shares one synchronous font ROM (1-cycle read latency) between NREQ
// requesters. One round-robin grant per vclock cycle; the byte returns on
// the next cycle with a one-hot rvalid strobe.
// Ports:
//   vclock     : pixel clock, only clock
//   reset_n    : asynchronous active-low reset
//   bus        : font_rom_arbiter_if.slave (requests, ROM, return path)
//   rr_ptr_dbg : current round-robin scan pointer
// Build option FONT_ARB_PRIO0_EN: requester 0 gets fixed top priority and
// does not move the pointer; requesters 1..NREQ-1 rotate among themselves.
// -----------------------------------------------------------------------------
module font_rom_arbiter
  import font_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NREQ_BITS = 2,
  parameter int ADDR_W    = FONT_ADDR_W,
  parameter int DATA_W    = FONT_DATA_W
) (
  input  logic                 vclock,
  input  logic                 reset_n,
  font_rom_arbiter_if.slave    bus,
  output logic [NREQ_BITS-1:0] rr_ptr_dbg
);

  logic [NREQ_BITS-1:0] rr_ptr;
  logic [ADDR_W-1:0]    last_addr;
  logic [NREQ-1:0]      rvalid_d;
  logic [15:0]          busy_cnt_q;

  logic [NREQ-1:0]      pick_req;
  logic [NREQ-1:0]      rr_gnt;
  logic [NREQ_BITS-1:0] rr_winner;
  logic                 rr_any;
  logic                 prio_hit;

  logic [NREQ-1:0]      win_gnt;
  logic [NREQ_BITS-1:0] win_idx;
  logic                 granted;
  logic [NREQ_BITS-1:0] next_ptr;
  logic                 multi_req;

`ifdef FONT_ARB_PRIO0_EN
  // Requester 0 is taken out of the rotation and serviced ahead of it.
  assign prio_hit = bus.req[0];
  assign pick_req = {bus.req[NREQ-1:1], 1'b0};
`else
  assign prio_hit = 1'b0;
  assign pick_req = bus.req;
`endif

  rr_pick #(
    .NREQ      (NREQ),
    .NREQ_BITS (NREQ_BITS)
  ) u_rr_pick (
    .req    (pick_req),
    .ptr    (rr_ptr),
    .gnt    (rr_gnt),
    .winner (rr_winner),
    .any    (rr_any)
  );

  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_winner;
    granted = reset_n & rr_any;
    if (prio_hit) begin
      win_gnt    = '0;
      win_gnt[0] = 1'b1;
      win_idx    = '0;
      granted    = reset_n;
    end
  end

  // Grants are suppressed while reset is asserted; with no grant the ROM
  // address parks on the last granted address so the ROM does not toggle.
  assign bus.gnt      = reset_n ? win_gnt : '0;
  assign bus.rom_addr = granted ? bus.req_addr[win_idx*ADDR_W +: ADDR_W] : last_addr;

  assign next_ptr  = (win_idx == NREQ_BITS'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign multi_req = ($countones(bus.req) >= 2);

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      last_addr  <= '0;
      rvalid_d   <= '0;
      busy_cnt_q <= '0;
    end else begin
      rvalid_d <= bus.gnt;
      if (granted) begin
        last_addr <= bus.rom_addr;
        if (!prio_hit) rr_ptr <= next_ptr;
      end
      if (multi_req && busy_cnt_q != 16'hFFFF) busy_cnt_q <= busy_cnt_q + 16'd1;
    end
  end

  // The ROM register is the only pipeline stage on the return path; its
  // output is forwarded during the strobe cycle and zeroed otherwise.
  assign bus.rvalid   = rvalid_d;
  assign bus.rdata    = (|rvalid_d) ? bus.rom_dout : '0;
  assign bus.busy_cnt = busy_cnt_q;
  assign rr_ptr_dbg   = rr_ptr;

endmodule
